// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//
// Sequential add/subtract unit. Two WIDTH-bit operands are combined DIGIT
// bits per clock, with the inter-slice carry held in a register so the
// combinational carry chain is only DIGIT bits long. An operation takes
// N = WIDTH/DIGIT RUN cycles.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds in_valid and the operands
// stable until in_ready is seen; the result (C, carry_out, overflow) stays
// stable while out_valid is high and the consumer has not yet raised
// out_ready.
//
// Optional build macro:
//   MULTICYCLE_ADDER_SATURATE_EN - on signed overflow, C is clamped to the
//   signed max (A non-negative) or the signed min (A negative). Flags are
//   not affected. When undefined, C wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH  operand/result width (multiple of DIGIT)
//   DIGIT  bits processed per clock, 1 <= DIGIT <= WIDTH
//
// Ports:
//   clk        clock, rising-edge active
//   rst        asynchronous, active-high reset (aborts any operation)
//   in_valid   operands and mode present
//   in_ready   unit can accept operands (low while rst is high)
//   A, B       operands
//   sub        0 = A+B, 1 = A-B
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   C          result
//   carry_out  carry out of the MSB; for subtract 1 means no borrow
//   overflow   two's-complement signed overflow
// -----------------------------------------------------------------------------
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             carry_out,
  output logic             overflow
);

  // ---------------------------------------------------------------------------
  // Parameter checks and derived constants
  // ---------------------------------------------------------------------------
  generate
    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
      $error("multicycle_adder: DIGIT must satisfy 1 <= DIGIT <= WIDTH");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
      $error("multicycle_adder: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;      // A, shifted right one slice per RUN cycle
  logic [WIDTH-1:0] b_reg;      // Beff (B or ~B), shifted like a_reg
  logic [WIDTH-1:0] c_reg;      // result, slices enter at the top
  logic             carry_reg;  // carry between slices
  logic [CNT_W-1:0] cnt;        // index of the slice being computed
  logic             co_reg;
  logic             ov_reg;

  // ---------------------------------------------------------------------------
  // Control signals
  // ---------------------------------------------------------------------------
  logic accept;
  logic last_slice;

  // ---------------------------------------------------------------------------
  // Slice datapath
  //
  // The operand registers shift right by DIGIT each cycle, so the slice being
  // worked on is always the low DIGIT bits; no wide multiplexer is needed.
  // The finished slice is pushed in at the top of c_reg and everything below
  // moves down, so after N cycles slice 0 has arrived at the bottom.
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] b_slice;
  logic [DIGIT:0]   slice_sum;
  logic             slice_ovf;
  logic [WIDTH-1:0] c_shifted;
  logic [WIDTH-1:0] c_final;

  assign a_slice   = a_reg[DIGIT-1:0];
  assign b_slice   = b_reg[DIGIT-1:0];
  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry_reg};

  // On the last slice the top bits of a_slice/b_slice are A[MSB]/Beff[MSB]
  // and slice_sum[DIGIT-1] is C[MSB]; overflow is decided from them.
  assign slice_ovf = (a_slice[DIGIT-1] == b_slice[DIGIT-1]) &&
                     (slice_sum[DIGIT-1] != a_slice[DIGIT-1]);

  generate
    if (DIGIT == WIDTH) begin : g_single_slice
      assign c_shifted = slice_sum[DIGIT-1:0];
    end else begin : g_multi_slice
      assign c_shifted = {slice_sum[DIGIT-1:0], c_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef MULTICYCLE_ADDER_SATURATE_EN
  // Clamp towards the sign of A: {0,1...1} for A >= 0, {1,0...0} for A < 0.
  assign c_final = slice_ovf ? {a_slice[DIGIT-1], {(WIDTH-1){~a_slice[DIGIT-1]}}}
                             : c_shifted;
`else
  assign c_final = c_shifted;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  //
  // DONE returns to IDLE on the transfer edge, so in_ready can only rise one
  // cycle later; a new operand can never be taken on the transfer edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        last_slice = (cnt == LAST_SLICE);
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      co_reg    <= 1'b0;
      ov_reg    <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
      a_reg     <= A;
      b_reg     <= sub ? ~B : B;
      carry_reg <= sub;
      cnt       <= '0;
    end else if (state == RUN) begin
      a_reg     <= a_reg >> DIGIT;
      b_reg     <= b_reg >> DIGIT;
      carry_reg <= slice_sum[DIGIT];
      cnt       <= cnt + CNT_W'(1);
      if (last_slice) begin
        c_reg  <= c_final;
        co_reg <= slice_sum[DIGIT];
        ov_reg <= slice_ovf;
      end else begin
        c_reg  <= c_shifted;
      end
    end
  end

  assign C         = c_reg;
  assign carry_out = co_reg;
  assign overflow  = ov_reg;

endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised, sequential successor to the team's 8-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock.
- Carry is held in a register between digit slices, so the carry chain is only DIGIT bits long.
- Valid/ready handshakes on input and output; sits between operand producers and result consumers in the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT, otherwise elaboration fails.
- DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= WIDTH. N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and mode present
- in_ready  out  1  block can accept operands
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A-B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- C  out  WIDTH  result
- carry_out  out  1  carry out of MSB; for subtract, 1 = no borrow
- overflow  out  1  two's-complement signed overflow

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; out_valid, C, carry_out, overflow = 0; digit counter and carry register = 0. in_ready is 0 while rst is high.
- States:
  - IDLE: in_ready = 1. Accept on edge where in_valid && in_ready. At accept: capture A, capture Beff = sub ? ~B : B, carry register = sub, counter = 0. Go to RUN.
  - RUN: in_ready = 0. Each edge computes slice i = counter: C[i*DIGIT +: DIGIT] = A_slice + Beff_slice + carry; the carry register takes the slice carry; counter++. After the slice with counter = N-1, go to DONE.
  - DONE: out_valid = 1; C, carry_out and overflow are stable. in_ready = 0; any in_valid is ignored. When out_ready = 1, transfer occurs on that edge: go to IDLE and clear out_valid. in_ready returns to 1 the cycle after the transfer; there is no accept in the same cycle as the transfer.
- Latency: accept edge t → out_valid high after edge t+N. DIGIT = WIDTH gives one RUN cycle.
- Flag rules:
  - carry_out = final carry register value.
  - overflow = (A[MSB] == Beff[MSB]) && (C[MSB] != A[MSB]).
  - Arithmetic is modulo 2^WIDTH; no result width growth.
- C may show partially written slices during RUN. C is only valid while out_valid = 1.
- If out_ready is already high when DONE is entered, transfer happens on the first DONE edge, so out_valid is high for one cycle.
- rst asserted in any state aborts the operation immediately. The result is discarded and nothing is emitted.

Optional Feature:
- Macro: MULTICYCLE_ADDER_SATURATE_EN.
- Defined: when overflow = 1, C is clamped at DONE entry to signed max (0111…1) if A[MSB] = 0, else signed min (1000…0). overflow and carry_out are unchanged.
- Undefined: C wraps modulo 2^WIDTH; no clamp logic is present.

Test Plan:
- Default params: A=2, B=2, sub=0 → C=4, carry_out=0, overflow=0; out_valid rises exactly 4 edges after accept.
- A=0xFFFFFFFF, B=1 → C=0, carry_out=1, overflow=0; checks carry propagation across all 4 slices.
- A=0x7FFFFFFF, B=1 → overflow=1, carry_out=0. C=0x80000000 without the macro; C=0x7FFFFFFF with MULTICYCLE_ADDER_SATURATE_EN.
- Subtract:
  - A=1, B=3, sub=1 → C=0xFFFFFFFE, carry_out=0, overflow=0.
  - A=5, B=5 → C=0, carry_out=1.
- WIDTH=8, DIGIT=1: A=0x92, B=0xAB → C=0x3D, carry_out=1, overflow=1, latency 8 edges.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE with in_valid=1 → outputs stable, in_ready=0, no new accept.
  - Then out_ready=1 → one transfer; in_ready=1 the next cycle.
  - Separately, pulse rst during the 2nd RUN cycle → out_valid stays 0 and in_ready=1 after release.
